mem_stage: RTL and testbench

- Memory-access pipeline stage between the EX/MEM register and the MEM/WB register.
- Non-memory results pass straight through.
- Loads and stores are run as byte-serial transactions on an 8-bit memory port (little-endian). The pipeline is stalled until the access completes.
- Load data is sign- or zero-extended according to the access type.

---
 rtl/mem_stage_if.sv | 26 ++
 rtl/mem_stage.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Byte-serial memory port used by mem_stage.
//   master (the pipeline stage): drives mem_req, mem_we, mem_a, mem_wdata;
//                                samples mem_rdata, mem_ready.
//   slave  (memory / bus side):  the mirror image.
// mem_rdata is valid in the cycle mem_ready is high. mem_ready is ignored
// while mem_req is low.
interface mem_stage_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_a, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_a, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX/MEM and MEM/WB.
//   Non-memory results pass straight through. Loads and stores run as
//   little-endian byte-serial transactions on an 8-bit port (mem_stage_if),
//   stalling the upstream pipeline until the access completes. Load data is
//   sign- or zero-extended by access type.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rd_data_i/addr_i/enable_i   ALU result and writeback control from EX/MEM
//   load_enable, store_enable, mem_addr, store_data, load_store_type
//                     memory operation request from EX/MEM
//   rd_data_o/addr_o/enable_o   result to MEM/WB
//   stall_req         freezes PC, IF/ID, ID/EX, EX/MEM while high
//   mem               byte memory port (master side)
//   misalign_o        only when MEM_MISALIGN_CHECK_EN is defined: pulses in
//                     the DONE cycle of a rejected misaligned H/W access
// Optional feature macro: MEM_MISALIGN_CHECK_EN
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              rd_enable_i,
    input  logic              load_enable,
    input  logic              store_enable,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic [3:0]        load_store_type,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [4:0]        rd_addr_o,
    output logic              rd_enable_o,
    output logic              stall_req,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic              misalign_o,
`endif
    mem_stage_if.master       mem
);

    // Access type codes: bit 3 marks the store forms, bits 1:0 the size.
    localparam logic [3:0] EXE_LB  = 4'd0;
    localparam logic [3:0] EXE_LH  = 4'd1;
    localparam logic [3:0] EXE_LW  = 4'd2;
    localparam logic [3:0] EXE_LBU = 4'd4;
    localparam logic [3:0] EXE_LHU = 4'd5;
    localparam logic [3:0] EXE_SB  = 4'd8;
    localparam logic [3:0] EXE_SH  = 4'd9;
    localparam logic [3:0] EXE_SW  = 4'd10;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    // Index of the final byte of an access (N-1).
    function automatic logic [1:0] last_cnt(input logic [3:0] t);
        case (t)
            EXE_LH, EXE_LHU, EXE_SH: last_cnt = 2'd1;
            EXE_LW, EXE_SW:          last_cnt = 2'd3;
            default:                 last_cnt = 2'd0;
        endcase
    endfunction

    // Extend the assembled little-endian buffer to register width.
    function automatic logic [DATA_W-1:0] extend(input logic [3:0] t,
                                                 input logic [DATA_W-1:0] d);
        case (t)
            EXE_LB:  extend = {{(DATA_W-8){d[7]}}, d[7:0]};
            EXE_LH:  extend = {{(DATA_W-16){d[15]}}, d[15:0]};
            EXE_LBU: extend = {{(DATA_W-8){1'b0}}, d[7:0]};
            EXE_LHU: extend = {{(DATA_W-16){1'b0}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

`ifdef MEM_MISALIGN_CHECK_EN
    // Halfwords need addr[0]==0, words need addr[1:0]==0.
    function automatic logic is_misaligned(input logic [3:0] t, input logic [1:0] a);
        case (t)
            EXE_LH, EXE_LHU, EXE_SH: is_misaligned = (a[0] != 1'b0);
            EXE_LW, EXE_SW:          is_misaligned = (a != 2'b00);
            default:                 is_misaligned = 1'b0;
        endcase
    endfunction
`endif

    logic [1:0]        state_r;
    logic [1:0]        cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [3:0]        type_r;
    logic [DATA_W-1:0] sdata_r;
    logic [DATA_W-1:0] buf_r;
    logic [4:0]        rd_r;
    logic              rd_en_r;
    logic              store_r;
    logic              misal_r;
    logic              mem_op_s;
    logic              misal_s;

    assign mem_op_s = load_enable | store_enable;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misal_s = is_misaligned(load_store_type, mem_addr[1:0]);
`else
    assign misal_s = 1'b0;
`endif

    // Transaction sequencer: capture in IDLE, walk the bytes in ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 2'd0;
            addr_r  <= '0;
            type_r  <= 4'd0;
            sdata_r <= '0;
            buf_r   <= '0;
            rd_r    <= 5'd0;
            rd_en_r <= 1'b0;
            store_r <= 1'b0;
            misal_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_op_s) begin
                        addr_r  <= mem_addr;
                        type_r  <= load_store_type;
                        sdata_r <= store_data;
                        buf_r   <= '0;
                        rd_r    <= rd_addr_i;
                        // A simultaneous store wins and suppresses writeback.
                        rd_en_r <= rd_enable_i & ~store_enable;
                        store_r <= store_enable;
                        cnt_r   <= 2'd0;
                        misal_r <= misal_s;
                        state_r <= misal_s ? DONE : ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (mem.mem_ready) begin
                        if (!store_r) begin
                            buf_r[{cnt_r, 3'b000} +: 8] <= mem.mem_rdata;
                        end else begin
                            buf_r <= buf_r;
                        end
                        cnt_r <= cnt_r + 2'd1;
                        if (cnt_r == last_cnt(type_r)) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= ACCESS;
                        end
                    end else begin
                        state_r <= ACCESS;
                    end
                end
                DONE: begin
                    cnt_r   <= 2'd0;
                    misal_r <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Memory port decode; the request is held stable while waiting because
    // it is derived purely from registered state.
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_a     = '0;
        mem.mem_wdata = 8'd0;
        if (state_r == ACCESS) begin
            mem.mem_req = 1'b1;
            mem.mem_we  = store_r;
            mem.mem_a   = addr_r + {{(ADDR_W-2){1'b0}}, cnt_r};
            if (store_r) begin
                mem.mem_wdata = sdata_r[{cnt_r, 3'b000} +: 8];
            end else begin
                mem.mem_wdata = 8'd0;
            end
        end else begin
            mem.mem_req = 1'b0;
        end
    end

    // Pipeline-facing outputs: pass-through when idle, bubble while busy,
    // load result in DONE.
    always_comb begin
        rd_data_o   = rd_data_i;
        rd_addr_o   = rd_addr_i;
        rd_enable_o = rd_enable_i;
        stall_req   = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        misalign_o  = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (mem_op_s) begin
                    stall_req   = 1'b1;
                    rd_enable_o = 1'b0;
                end else begin
                    stall_req   = 1'b0;
                end
            end
            ACCESS: begin
                stall_req   = 1'b1;
                rd_data_o   = '0;
                rd_addr_o   = rd_r;
                rd_enable_o = 1'b0;
            end
            DONE: begin
                rd_addr_o = rd_r;
                if (misal_r) begin
                    rd_data_o   = '0;
                    rd_enable_o = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
                    misalign_o  = 1'b1;
`endif
                end else if (store_r) begin
                    rd_data_o   = '0;
                    rd_enable_o = 1'b0;
                end else begin
                    rd_data_o   = extend(type_r, buf_r);
                    rd_enable_o = rd_en_r;
                end
            end
            default: begin
                rd_data_o   = '0;
                rd_addr_o   = 5'd0;
                rd_enable_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam logic [3:0] T_LB  = 4'd0;
    localparam logic [3:0] T_LH  = 4'd1;
    localparam logic [3:0] T_LW  = 4'd2;
    localparam logic [3:0] T_LBU = 4'd4;
    localparam logic [3:0] T_SB  = 4'd8;
    localparam logic [3:0] T_SH  = 4'd9;
    localparam logic [3:0] T_SW  = 4'd10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rd_data_i;
    logic [4:0]  rd_addr_i;
    logic        rd_enable_i;
    logic        load_enable;
    logic        store_enable;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic [3:0]  load_store_type;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;
    logic        rd_enable_o;
    logic        stall_req;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int passed = 0;
    int total  = 0;
    int stall_seen;

    mem_stage_if #(.ADDR_W(32)) mif ();

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_data_i       (rd_data_i),
        .rd_addr_i       (rd_addr_i),
        .rd_enable_i     (rd_enable_i),
        .load_enable     (load_enable),
        .store_enable    (store_enable),
        .mem_addr        (mem_addr),
        .store_data      (store_data),
        .load_store_type (load_store_type),
        .rd_data_o       (rd_data_o),
        .rd_addr_o       (rd_addr_o),
        .rd_enable_o     (rd_enable_o),
        .stall_req       (stall_req),
`ifdef MEM_MISALIGN_CHECK_EN
        .misalign_o      (misalign_o),
`endif
        .mem             (mif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one memory op from IDLE and walk it to the DONE cycle.
    // gap = wait cycles before each mem_ready pulse; rbytes = read bytes, LE.
    task automatic mem_op(input string tag, input logic [3:0] t, input logic ld,
                          input logic st, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rbytes,
                          input int n, input int gap);
        logic [31:0] ea;
        logic [7:0]  eb;
        stall_seen      = 0;
        load_enable     = ld;
        store_enable    = st;
        load_store_type = t;
        mem_addr        = addr;
        store_data      = sdata;
        #1;
        chk({tag, " idle stall"}, {31'd0, stall_req}, 32'd1);
        chk({tag, " idle req"}, {31'd0, mif.mem_req}, 32'd0);
        chk({tag, " idle rd_en"}, {31'd0, rd_enable_o}, 32'd0);
        if (stall_req) stall_seen++;
        for (int i = 0; i < n; i++) begin
            ea = addr + i;
            eb = sdata[8*i +: 8];
            for (int w = 0; w <= gap; w++) begin
                tick();
                mif.mem_ready = (w == gap);
                mif.mem_rdata = rbytes[8*i +: 8];
                #1;
                chk({tag, " req"}, {31'd0, mif.mem_req}, 32'd1);
                chk({tag, " addr"}, mif.mem_a, ea);
                chk({tag, " we"}, {31'd0, mif.mem_we}, {31'd0, st});
                if (st) chk({tag, " wdata"}, {24'd0, mif.mem_wdata}, {24'd0, eb});
                if (stall_req) stall_seen++;
            end
        end
        tick();
        mif.mem_ready = 1'b0;
        #1;
        chk({tag, " done stall"}, {31'd0, stall_req}, 32'd0);
        chk({tag, " done req"}, {31'd0, mif.mem_req}, 32'd0);
    endtask

    // Leave DONE and return the inputs to an idle ALU op.
    task automatic end_op(input string tag);
        tick();
        load_enable  = 1'b0;
        store_enable = 1'b0;
        #1;
        chk({tag, " back idle stall"}, {31'd0, stall_req}, 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        rd_data_i       = 32'd0;
        rd_addr_i       = 5'd0;
        rd_enable_i     = 1'b0;
        load_enable     = 1'b0;
        store_enable    = 1'b0;
        mem_addr        = 32'd0;
        store_data      = 32'd0;
        load_store_type = 4'd0;
        mif.mem_rdata   = 8'd0;
        mif.mem_ready   = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst stall", {31'd0, stall_req}, 32'd0);
        chk("rst req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst we", {31'd0, mif.mem_we}, 32'd0);
        chk("rst addr", mif.mem_a, 32'd0);
        chk("rst wdata", {24'd0, mif.mem_wdata}, 32'd0);
        chk("rst rd_en", {31'd0, rd_enable_o}, 32'd0);

        // ALU pass-through, with a stray mem_ready that must be ignored
        rd_data_i     = 32'h0000_1234;
        rd_addr_i     = 5'd5;
        rd_enable_i   = 1'b1;
        mif.mem_ready = 1'b1;
        #1;
        chk("pass data", rd_data_o, 32'h0000_1234);
        chk("pass addr", {27'd0, rd_addr_o}, 32'd5);
        chk("pass en", {31'd0, rd_enable_o}, 32'd1);
        chk("pass stall", {31'd0, stall_req}, 32'd0);
        tick();
        chk("pass req", {31'd0, mif.mem_req}, 32'd0);
        chk("pass data 2", rd_data_o, 32'h0000_1234);
        mif.mem_ready = 1'b0;

        // LW 0x100, zero-wait
        rd_addr_i = 5'd7;
        mem_op("lw", T_LW, 1'b1, 1'b0, 32'h0000_0100, 32'd0, 32'h1234_5678, 4, 0);
        chk("lw stall cycles", stall_seen, 32'd5);
        chk("lw data", rd_data_o, 32'h1234_5678);
        chk("lw rd", {27'd0, rd_addr_o}, 32'd7);
        chk("lw en", {31'd0, rd_enable_o}, 32'd1);
        end_op("lw");

        // LB / LBU / LH extension
        mem_op("lb", T_LB, 1'b1, 1'b0, 32'h0000_0003, 32'd0, 32'h0000_0080, 1, 0);
        chk("lb stall cycles", stall_seen, 32'd2);
        chk("lb data", rd_data_o, 32'hFFFF_FF80);
        chk("lb en", {31'd0, rd_enable_o}, 32'd1);
        end_op("lb");
        mem_op("lbu", T_LBU, 1'b1, 1'b0, 32'h0000_0003, 32'd0, 32'h0000_0080, 1, 0);
        chk("lbu data", rd_data_o, 32'h0000_0080);
        end_op("lbu");
        mem_op("lh", T_LH, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'h0000_8000, 2, 0);
        chk("lh stall cycles", stall_seen, 32'd3);
        chk("lh data", rd_data_o, 32'hFFFF_8000);
        end_op("lh");

        // Load+store together: store wins, no writeback
        mem_op("sb both", T_SB, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055, 32'd0, 1, 0);
        chk("sb both en", {31'd0, rd_enable_o}, 32'd0);
        end_op("sb both");

`ifndef MEM_MISALIGN_CHECK_EN
        // SH across a boundary with mem_ready every 3rd cycle
        mem_op("sh", T_SH, 1'b0, 1'b1, 32'h1FFF_FFFF, 32'hAABB_CCDD, 32'd0, 2, 2);
        chk("sh stall cycles", stall_seen, 32'd7);
        chk("sh en", {31'd0, rd_enable_o}, 32'd0);
        end_op("sh");

        // SW wrapping the address space
        mem_op("sw", T_SW, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0403_0201, 32'd0, 4, 0);
        chk("sw en", {31'd0, rd_enable_o}, 32'd0);
        end_op("sw");
`endif

        // Reset in the 2nd ACCESS cycle of an LW
        load_store_type = T_LW;
        mem_addr        = 32'h0000_0200;
        load_enable     = 1'b1;
        #1;
        tick();
        mif.mem_ready = 1'b1;
        mif.mem_rdata = 8'hAA;
        #1;
        chk("rstacc a0", mif.mem_a, 32'h0000_0200);
        tick();
        rst         = 1'b1;
        load_enable = 1'b0;
        rd_enable_i = 1'b0;
        #1;
        chk("rstacc a1", mif.mem_a, 32'h0000_0201);
        tick();
        rst = 1'b0;
        #1;
        chk("rstacc req", {31'd0, mif.mem_req}, 32'd0);
        chk("rstacc stall", {31'd0, stall_req}, 32'd0);
        chk("rstacc en", {31'd0, rd_enable_o}, 32'd0);
        tick();
        chk("rstacc req 2", {31'd0, mif.mem_req}, 32'd0);
        mif.mem_ready = 1'b0;

`ifdef MEM_MISALIGN_CHECK_EN
        // Misaligned LW is rejected without touching memory
        rd_enable_i     = 1'b1;
        load_store_type = T_LW;
        mem_addr        = 32'h0000_0102;
        load_enable     = 1'b1;
        #1;
        chk("mis stall", {31'd0, stall_req}, 32'd1);
        chk("mis flag idle", {31'd0, misalign_o}, 32'd0);
        tick();
        chk("mis req", {31'd0, mif.mem_req}, 32'd0);
        chk("mis flag", {31'd0, misalign_o}, 32'd1);
        chk("mis en", {31'd0, rd_enable_o}, 32'd0);
        chk("mis done stall", {31'd0, stall_req}, 32'd0);
        end_op("mis");
        chk("mis flag clr", {31'd0, misalign_o}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
